// File: rtl/ctrl_unit_mc.sv
// Multi-cycle control unit: owns the program counter and instruction register and
// sequences each instruction FETCH -> DECODE -> EXEC/MEM/OUT -> FETCH (or HALT).
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   ifetch_req/addr/ack/data   stalling instruction fetch handshake (addr = pc)
//   addr_a, addr_b             register-file selects (addr_b doubles as immediate)
//   reset, reset_all, load     register-file clear/clear-all/write controls
//   mb_select, mem_select      Bus B and Bus D source selects
//   ALU_opcode, alu_zero       ALU operation and its zero flag
//   mem_read/write/addr/ack    stalling data-memory handshake
//   out_valid, out_ready       output handshake (data = register addr_a)
//   pc, halted                 program counter and stop indication
module ctrl_unit_mc #(
  parameter int unsigned OPC_W = 4,
  parameter int unsigned ARG_W = 6,
  parameter int unsigned RA_W  = 3,
  parameter int unsigned PC_W  = 8,
  parameter int unsigned MA_W  = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   ifetch_req,
  output logic [PC_W-1:0]        ifetch_addr,
  input  logic                   ifetch_ack,
  input  logic [OPC_W+ARG_W-1:0] ifetch_data,
  output logic [RA_W-1:0]        addr_a,
  output logic [RA_W-1:0]        addr_b,
  output logic                   reset,
  output logic                   reset_all,
  output logic                   load,
  output logic                   mb_select,
  output logic                   mem_select,
  output logic [3:0]             ALU_opcode,
  input  logic                   alu_zero,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [MA_W-1:0]        mem_addr,
  input  logic                   mem_ack,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_W-1:0]        pc,
  output logic                   halted
);
  localparam int unsigned IW = OPC_W + ARG_W;

  localparam logic [OPC_W-1:0] OpAdd   = OPC_W'(4'h0);
  localparam logic [OPC_W-1:0] OpSub   = OPC_W'(4'h1);
  localparam logic [OPC_W-1:0] OpAddi  = OPC_W'(4'h2);
  localparam logic [OPC_W-1:0] OpSubi  = OPC_W'(4'h3);
  localparam logic [OPC_W-1:0] OpMul2  = OPC_W'(4'h4);
  localparam logic [OPC_W-1:0] OpDiv2  = OPC_W'(4'h5);
  localparam logic [OPC_W-1:0] OpClr   = OPC_W'(4'h6);
  localparam logic [OPC_W-1:0] OpRst   = OPC_W'(4'h7);
  localparam logic [OPC_W-1:0] OpMov   = OPC_W'(4'h8);
  localparam logic [OPC_W-1:0] OpJmp   = OPC_W'(4'h9);
  localparam logic [OPC_W-1:0] OpOut   = OPC_W'(4'hA);
  localparam logic [OPC_W-1:0] OpLoad  = OPC_W'(4'hB);
  localparam logic [OPC_W-1:0] OpStore = OPC_W'(4'hC);
  localparam logic [OPC_W-1:0] OpJz    = OPC_W'(4'hD);
  localparam logic [OPC_W-1:0] OpHalt  = OPC_W'(4'hF);

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StOut, StHalt} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     ir_q, ir_d;
  logic [PC_W-1:0]   pc_q, pc_d;

  // Registered outputs, decoded from the next state so they line up with state_q.
  logic              ifetch_req_q, ifetch_req_d;
  logic [RA_W-1:0]   addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic              reset_q, reset_d, reset_all_q, reset_all_d;
  logic              load_q, load_d, mb_select_q, mb_select_d;
  logic              mem_select_q, mem_select_d;
  logic [3:0]        alu_q, alu_d;
  logic              mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [MA_W-1:0]   mem_addr_q, mem_addr_d;
  logic              out_valid_q, out_valid_d, halted_q, halted_d;

  logic [OPC_W-1:0]  opc_q, opc_d;
  logic [ARG_W-1:0]  arg_q, arg_d;
  logic [RA_W-1:0]   ra_d, rb_d;
  logic [PC_W-1:0]   target;

  assign opc_q  = ir_q[IW-1:ARG_W];
  assign arg_q  = ir_q[ARG_W-1:0];
  assign opc_d  = ir_d[IW-1:ARG_W];
  assign arg_d  = ir_d[ARG_W-1:0];
  assign ra_d   = arg_d[2*RA_W-1:RA_W];
  assign rb_d   = arg_d[RA_W-1:0];
  assign target = PC_W'(arg_q);

  // Next state, IR and PC.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    unique case (state_q)
      StFetch: begin
        // Only an ack answering our own request counts.
        if (ifetch_req_q && ifetch_ack) begin
          ir_d    = ifetch_data;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (opc_q == OpLoad || opc_q == OpStore) state_d = StMem;
        else if (opc_q == OpOut)                 state_d = StOut;
        else if (opc_q == OpHalt)                state_d = StHalt;
        else                                     state_d = StExec;
      end
      StExec: begin
        state_d = StFetch;
        if (opc_q == OpJmp || (opc_q == OpJz && alu_zero)) pc_d = target;
        else                                               pc_d = pc_q + 1'b1;
      end
      StMem: begin
        if (mem_ack) begin
          state_d = StFetch;
          pc_d    = pc_q + 1'b1;
        end
      end
      StOut: begin
        if (out_ready) begin
          state_d = StFetch;
          pc_d    = pc_q + 1'b1;
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  // Output decode for the state being entered.
  always_comb begin
    ifetch_req_d = 1'b0;
    addr_a_d     = '0;
    addr_b_d     = '0;
    reset_d      = 1'b0;
    reset_all_d  = 1'b0;
    load_d       = 1'b0;
    mb_select_d  = 1'b0;
    mem_select_d = 1'b0;
    alu_d        = 4'h0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_addr_d   = '0;
    out_valid_d  = 1'b0;
    halted_d     = 1'b0;
    unique case (state_d)
      StFetch: ifetch_req_d = 1'b1;
      StExec: begin
        unique case (opc_d)
          OpAdd, OpSub, OpMov: begin
            addr_a_d    = ra_d;
            addr_b_d    = rb_d;
            mb_select_d = 1'b1;
            load_d      = 1'b1;
            alu_d       = (opc_d == OpSub) ? 4'h1 : (opc_d == OpMov) ? 4'h4 : 4'h0;
          end
          OpAddi, OpSubi: begin
            addr_a_d = ra_d;
            addr_b_d = rb_d;
            load_d   = 1'b1;
            alu_d    = (opc_d == OpSubi) ? 4'h1 : 4'h0;
          end
          OpMul2, OpDiv2: begin
            addr_a_d = ra_d;
            load_d   = 1'b1;
            alu_d    = (opc_d == OpDiv2) ? 4'h3 : 4'h2;
          end
          OpClr: begin
            addr_a_d = ra_d;
            reset_d  = 1'b1;
          end
          OpRst: reset_all_d = 1'b1;
          OpJz: begin
            // Pass R0 through the ALU so alu_zero reflects R0 == 0.
            alu_d       = 4'h4;
            mb_select_d = 1'b1;
          end
          default: ;
        endcase
      end
      StMem: begin
        mem_addr_d = arg_d[MA_W-1:0];
        if (opc_d == OpLoad) begin
          mem_read_d   = 1'b1;
          mem_select_d = 1'b1;
        end else begin
          mem_write_d = 1'b1;
        end
      end
      StOut: begin
        out_valid_d = 1'b1;
        addr_a_d    = ra_d;
      end
      StHalt:  halted_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StFetch;
      ir_q         <= '0;
      pc_q         <= '0;
      ifetch_req_q <= 1'b0;
      addr_a_q     <= '0;
      addr_b_q     <= '0;
      reset_q      <= 1'b0;
      reset_all_q  <= 1'b0;
      load_q       <= 1'b0;
      mb_select_q  <= 1'b0;
      mem_select_q <= 1'b0;
      alu_q        <= 4'h0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      out_valid_q  <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      pc_q         <= pc_d;
      ifetch_req_q <= ifetch_req_d;
      addr_a_q     <= addr_a_d;
      addr_b_q     <= addr_b_d;
      reset_q      <= reset_d;
      reset_all_q  <= reset_all_d;
      load_q       <= load_d;
      mb_select_q  <= mb_select_d;
      mem_select_q <= mem_select_d;
      alu_q        <= alu_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      out_valid_q  <= out_valid_d;
      halted_q     <= halted_d;
    end
  end

  assign ifetch_req  = ifetch_req_q;
  assign ifetch_addr = pc_q;
  assign addr_a      = addr_a_q;
  assign addr_b      = addr_b_q;
  assign reset       = reset_q;
  assign reset_all   = reset_all_q;
  // LOAD writes the register only in the cycle the memory completes.
  assign load        = load_q | (mem_read_q & mem_ack);
  assign mb_select   = mb_select_q;
  assign mem_select  = mem_select_q;
  assign ALU_opcode  = alu_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_addr    = mem_addr_q;
  assign out_valid   = out_valid_q;
  assign pc          = pc_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_ctrl_unit_mc.sv
`timescale 1ns/1ps
module tb_ctrl_unit_mc;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Default-parameter DUT
  logic       ifetch_req, ifetch_ack;
  logic [7:0] ifetch_addr, pc;
  logic [9:0] ifetch_data;
  logic [2:0] addr_a, addr_b;
  logic       reset, reset_all, load, mb_select, mem_select, halted;
  logic [3:0] alu_opcode;
  logic       alu_zero, mem_read, mem_write, mem_ack, out_valid, out_ready;
  logic [5:0] mem_addr;

  // Wide-parameter DUT
  logic        p_ifetch_req, p_ifetch_ack;
  logic [9:0]  p_ifetch_addr, p_pc;
  logic [11:0] p_ifetch_data;
  logic [3:0]  p_addr_a, p_addr_b;
  logic        p_reset, p_reset_all, p_load, p_mb_select, p_mem_select, p_halted;
  logic [3:0]  p_alu_opcode;
  logic        p_alu_zero, p_mem_read, p_mem_write, p_mem_ack, p_out_valid, p_out_ready;
  logic [7:0]  p_mem_addr;

  ctrl_unit_mc dut (
    .clk(clk), .rst_n(rst_n),
    .ifetch_req(ifetch_req), .ifetch_addr(ifetch_addr), .ifetch_ack(ifetch_ack),
    .ifetch_data(ifetch_data), .addr_a(addr_a), .addr_b(addr_b), .reset(reset),
    .reset_all(reset_all), .load(load), .mb_select(mb_select), .mem_select(mem_select),
    .ALU_opcode(alu_opcode), .alu_zero(alu_zero), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .out_valid(out_valid), .out_ready(out_ready), .pc(pc), .halted(halted)
  );

  ctrl_unit_mc #(.OPC_W(4), .ARG_W(8), .RA_W(4), .PC_W(10), .MA_W(8)) dut_p (
    .clk(clk), .rst_n(rst_n),
    .ifetch_req(p_ifetch_req), .ifetch_addr(p_ifetch_addr), .ifetch_ack(p_ifetch_ack),
    .ifetch_data(p_ifetch_data), .addr_a(p_addr_a), .addr_b(p_addr_b), .reset(p_reset),
    .reset_all(p_reset_all), .load(p_load), .mb_select(p_mb_select),
    .mem_select(p_mem_select), .ALU_opcode(p_alu_opcode), .alu_zero(p_alu_zero),
    .mem_read(p_mem_read), .mem_write(p_mem_write), .mem_addr(p_mem_addr),
    .mem_ack(p_mem_ack), .out_valid(p_out_valid), .out_ready(p_out_ready), .pc(p_pc),
    .halted(p_halted)
  );

  // Expected EXEC controls: alu, a, b, load, mb_select, reset, reset_all
  typedef struct packed {
    logic [3:0] alu;
    logic [2:0] a;
    logic [2:0] b;
    logic       ld, mb, rst, rsta;
  } ctl_t;

  typedef struct {
    logic [9:0] ins;
    logic       z;
    ctl_t       exp;
    logic       jmp;
    logic [7:0] tgt;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] mpc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: controls an EXEC-class instruction must show, from the opcode table.
  function automatic ctl_t model_exec(input logic [9:0] ins);
    logic [3:0] op;
    logic [2:0] ra, rb;
    ctl_t c;
    op = ins[9:6];
    ra = ins[5:3];
    rb = ins[2:0];
    c  = '0;
    case (op)
      4'h0: c = {4'h0, ra, rb, 4'b1100};
      4'h1: c = {4'h1, ra, rb, 4'b1100};
      4'h2: c = {4'h0, ra, rb, 4'b1000};
      4'h3: c = {4'h1, ra, rb, 4'b1000};
      4'h4: c = {4'h2, ra, 3'd0, 4'b1000};
      4'h5: c = {4'h3, ra, 3'd0, 4'b1000};
      4'h6: c = {4'h0, ra, 3'd0, 4'b0010};
      4'h7: c = {4'h0, 3'd0, 3'd0, 4'b0001};
      4'h8: c = {4'h4, ra, rb, 4'b1100};
      4'hD: c = {4'h4, 3'd0, 3'd0, 4'b0100};
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] model_pc(input logic [7:0] p, input logic [9:0] ins,
                                          input logic z);
    if (ins[9:6] == 4'h9 || (ins[9:6] == 4'hD && z)) return {2'b00, ins[5:0]};
    return p + 8'd1;
  endfunction

  // Waits (bounded) for a fetch request, then answers it with zero wait states.
  task automatic do_fetch(input logic [9:0] ins);
    int n = 0;
    while (!ifetch_req && n < 20) begin
      step();
      n++;
    end
    check("fetch_req", 32'(ifetch_req), 32'd1);
    check("fetch_addr", 32'(ifetch_addr), 32'(mpc));
    ifetch_data = ins;
    ifetch_ack  = 1'b1;
    step();
    ifetch_ack  = 1'b0;
    ifetch_data = '0;
    check("decode_quiet", 32'({ifetch_req, load, mem_read, mem_write, out_valid}), 32'd0);
  endtask

  task automatic run_exec(input logic [9:0] ins, input logic z, input ctl_t exp,
                          input logic [7:0] exp_pc, input string tag);
    ctl_t got;
    do_fetch(ins);
    alu_zero = z;
    step();
    got = {alu_opcode, addr_a, addr_b, load, mb_select, reset, reset_all};
    check($sformatf("%s ctl", tag), 32'(got), 32'(exp));
    check($sformatf("%s exec_quiet", tag),
          32'({ifetch_req, mem_read, mem_write, out_valid, mem_select}), 32'd0);
    step();
    alu_zero = 1'b0;
    check($sformatf("%s pc", tag), 32'(pc), 32'(exp_pc));
    check($sformatf("%s next_fetch", tag), 32'({ifetch_req, load}), 32'b10);
    mpc = exp_pc;
  endtask

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{10'b0000_001_010, 1'b0, 14'b0000_001_010_1100, 1'b0, 8'd0};
    tbl[1]  = '{10'b0001_011_100, 1'b0, 14'b0001_011_100_1100, 1'b0, 8'd0};
    tbl[2]  = '{10'b0010_101_111, 1'b0, 14'b0000_101_111_1000, 1'b0, 8'd0};
    tbl[3]  = '{10'b0011_110_001, 1'b0, 14'b0001_110_001_1000, 1'b0, 8'd0};
    tbl[4]  = '{10'b0100_010_011, 1'b0, 14'b0010_010_000_1000, 1'b0, 8'd0};
    tbl[5]  = '{10'b0101_111_101, 1'b0, 14'b0011_111_000_1000, 1'b0, 8'd0};
    tbl[6]  = '{10'b0110_100_011, 1'b0, 14'b0000_100_000_0010, 1'b0, 8'd0};
    tbl[7]  = '{10'b0111_011_011, 1'b0, 14'b0000_000_000_0001, 1'b0, 8'd0};
    tbl[8]  = '{10'b1000_001_110, 1'b0, 14'b0100_001_110_1100, 1'b0, 8'd0};
    tbl[9]  = '{10'b1001_000_101, 1'b0, 14'b0,                 1'b1, 8'd5};
    tbl[10] = '{10'b1101_111_111, 1'b1, 14'b0100_000_000_0100, 1'b1, 8'h3F};
    tbl[11] = '{10'b1101_000_010, 1'b0, 14'b0100_000_000_0100, 1'b0, 8'd0};
    tbl[12] = '{10'b1110_101_010, 1'b0, 14'b0,                 1'b0, 8'd0};

    rst_n = 1'b0;
    ifetch_ack = 1'b0; ifetch_data = '0; alu_zero = 1'b0; mem_ack = 1'b0; out_ready = 1'b0;
    p_ifetch_ack = 1'b0; p_ifetch_data = '0; p_alu_zero = 1'b0; p_mem_ack = 1'b0;
    p_out_ready = 1'b0;
    mpc = 8'd0;

    // Reset state
    repeat (2) step();
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_outputs", 32'({ifetch_req, addr_a, addr_b, reset, reset_all, load, mb_select,
          mem_select, alu_opcode, mem_read, mem_write, mem_addr, out_valid}), 32'd0);
    rst_n = 1'b1;
    step();
    check("first_fetch_req", 32'(ifetch_req), 32'd1);
    check("first_fetch_addr", 32'(ifetch_addr), 32'd0);

    // Table-driven EXEC instructions
    for (int i = 0; i < 13; i++) begin
      run_exec(tbl[i].ins, tbl[i].z, tbl[i].exp,
               tbl[i].jmp ? tbl[i].tgt : mpc + 8'd1, $sformatf("vec%0d", i));
    end

    // LOAD 0x15 with ack four cycles late
    do_fetch(10'b1011_010101);
    step();
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        mem_ack = 1'b1;
        #1;
      end
      check("load_mem_read", 32'(mem_read), 32'd1);
      check("load_mem_addr", 32'(mem_addr), 32'h15);
      check("load_ctl", 32'({mem_select, addr_a, mem_write}), 32'b1_000_0);
      check("load_we", 32'(load), (i == 4) ? 32'd1 : 32'd0);
      if (i < 4) step();
    end
    step();
    mem_ack = 1'b0;
    check("load_done", 32'({mem_read, load}), 32'd0);
    check("load_pc", 32'(pc), 32'(mpc + 8'd1));
    mpc = mpc + 8'd1;

    // STORE 0x0F with immediate ack
    do_fetch(10'b1100_001111);
    step();
    check("store_ctl", 32'({mem_write, mem_read, mem_select, load}), 32'b1000);
    check("store_addr", 32'(mem_addr), 32'h0F);
    mem_ack = 1'b1;
    #1;
    check("store_no_load", 32'(load), 32'd0);
    step();
    mem_ack = 1'b0;
    check("store_pc", 32'(pc), 32'(mpc + 8'd1));
    mpc = mpc + 8'd1;

    // OUT R5 with sink stalled 3 cycles; stray acks must be ignored
    do_fetch(10'b1010_101000);
    step();
    mem_ack = 1'b1;
    ifetch_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("out_valid_wait", 32'(out_valid), 32'd1);
      check("out_addr_wait", 32'(addr_a), 32'd5);
      check("out_pc_hold", 32'(pc), 32'(mpc));
      step();
    end
    mem_ack = 1'b0;
    ifetch_ack = 1'b0;
    out_ready = 1'b1;
    check("out_valid_acc", 32'({out_valid, addr_a}), 32'b1_101);
    step();
    out_ready = 1'b0;
    check("out_released", 32'(out_valid), 32'd0);
    check("out_pc", 32'(pc), 32'(mpc + 8'd1));
    mpc = mpc + 8'd1;

    // Random EXEC-class instructions against the reference model
    for (int i = 0; i < 60; i++) begin
      logic [3:0] op;
      logic [9:0] ins;
      logic z;
      int r;
      r   = $urandom_range(0, 11);
      op  = (r < 10) ? 4'(r) : ((r == 10) ? 4'hD : 4'hE);
      ins = {op, 6'($urandom_range(0, 63))};
      z   = 1'($urandom_range(0, 1));
      run_exec(ins, z, model_exec(ins), model_pc(mpc, ins, z), $sformatf("rnd%0d", i));
    end

    // JMP 0x3F, walk non-branch instructions up to 0xFF, then NOP wraps to 0
    run_exec(10'b1001_111111, 1'b0, '0, 8'h3F, "jmp3f");
    for (int n = 0; n < 300 && mpc != 8'hFF; n++) begin
      logic [3:0] op;
      logic [9:0] ins;
      op  = 4'($urandom_range(0, 9));
      if (op == 4'h9) op = 4'hE;
      ins = {op, 6'($urandom_range(0, 63))};
      run_exec(ins, 1'b0, model_exec(ins), model_pc(mpc, ins, 1'b0), "walk");
    end
    check("walk_reached_ff", 32'(pc), 32'hFF);
    run_exec(10'b1110_000000, 1'b0, '0, 8'h00, "wrap_nop");

    // HALT holds until reset, ignoring fetch acks
    do_fetch(10'b1111_000000);
    step();
    ifetch_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("halt_state", 32'({halted, ifetch_req}), 32'b10);
      step();
    end
    ifetch_ack = 1'b0;
    check("halt_pc_frozen", 32'(pc), 32'(mpc));
    #2 rst_n = 1'b0;
    #1;
    check("halt_rst", 32'({halted, pc}), 32'd0);
    #1 rst_n = 1'b1;
    mpc = 8'd0;
    step();
    check("halt_restart", 32'({ifetch_req, ifetch_addr}), 32'h100);

    // Reset in the middle of a MEM wait
    do_fetch(10'b1011_000111);
    step();
    step();
    check("midmem_read", 32'(mem_read), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midmem_async_drop", 32'({mem_read, mem_select, pc}), 32'd0);
    #1 rst_n = 1'b1;
    step();
    check("midmem_restart", 32'({ifetch_req, ifetch_addr}), 32'h100);

    // Wide parameter set: field extraction and jump zero-extension
    check("p_fetch_req", 32'(p_ifetch_req), 32'd1);
    p_ifetch_data = 12'b0000_1010_0101;
    p_ifetch_ack  = 1'b1;
    step();
    p_ifetch_ack = 1'b0;
    step();
    check("p_add_ctl", 32'({p_addr_a, p_addr_b, p_load, p_mb_select}), 32'b1010_0101_1_1);
    step();
    check("p_add_pc", 32'(p_pc), 32'd1);
    p_ifetch_data = 12'b1001_1100_1000;
    p_ifetch_ack  = 1'b1;
    step();
    p_ifetch_ack = 1'b0;
    step();
    step();
    check("p_jmp_pc", 32'(p_pc), 32'h0C8);
    p_ifetch_data = 12'b1011_1010_1011;
    p_ifetch_ack  = 1'b1;
    step();
    p_ifetch_ack = 1'b0;
    step();
    check("p_load_mem", 32'({p_mem_read, p_mem_addr}), 32'h1AB);
    p_mem_ack = 1'b1;
    #1;
    check("p_load_we", 32'(p_load), 32'd1);
    step();
    p_mem_ack = 1'b0;
    check("p_load_pc", 32'(p_pc), 32'h0C9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
